// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS controller.
// Owns the PC, the instruction register and a FETCH/DECODE/EXEC/MEM/WB sequencer.
// Instruction and data memories use a ready handshake, so wait states are tolerated.
// Datapath controls are decoded from the state and ir registers.
// Each control is asserted only in the state where it is valid.
// Optional feature macro: MIPS_CTRL_PERF_EN adds the cyc_cnt and ret_cnt counters.
module mips_multicycle_ctrl #(
  parameter int               ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_rd,
  output logic              dmem_wr,
  input  logic              dmem_ready,
  input  logic              alu_zero,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] pc,
  output logic              reg_dst,
  output logic              alu_src,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic [1:0]        alu_op,
  output logic [2:0]        state,
  output logic              illegal
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       ret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  state_t            state_r;
  logic [31:0]       ir_r;
  logic [ADDR_W-1:0] pc_r;
  logic              rst_q;   // high in the cycle right after reset: keeps requests quiet
  logic [5:0]        opcode;
  logic              is_r, is_lw, is_sw, is_beq, is_j, is_addi, is_ill;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] br_off;

  assign opcode    = ir_r[31:26];
  assign ir        = ir_r;
  assign pc        = pc_r;
  assign imem_addr = pc_r;
  assign state     = state_r;

  // Opcode classification of the held instruction.
  always_comb begin
    is_r    = (opcode == OP_R);
    is_lw   = (opcode == OP_LW);
    is_sw   = (opcode == OP_SW);
    is_beq  = (opcode == OP_BEQ);
    is_j    = (opcode == OP_J);
    is_addi = (opcode == OP_ADDI);
    is_ill  = !(is_r || is_lw || is_sw || is_beq || is_j || is_addi);
  end

  // Jump target keeps the PC bits above 28; branch offset is the sign-extended word offset.
  always_comb begin
    jump_tgt = '0;
    br_off   = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (i < 2) begin
        jump_tgt[i] = 1'b0;
        br_off[i]   = 1'b0;
      end else begin
        if (i < 28) begin
          jump_tgt[i] = ir_r[i-2];
        end else begin
          jump_tgt[i] = pc_r[i];
        end
        if (i < 18) begin
          br_off[i] = ir_r[i-2];
        end else begin
          br_off[i] = ir_r[15];
        end
      end
    end
  end

  // Per-state control decode; everything is zero outside its own state.
  always_comb begin
    imem_req   = 1'b0;
    dmem_rd    = 1'b0;
    dmem_wr    = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    case (state_r)
      S_FETCH: begin
        imem_req = !rst_q;
      end
      S_DECODE: begin
        illegal = is_ill;
      end
      S_EXEC: begin
        if (is_r) begin
          alu_op = 2'b10;
        end else if (is_beq) begin
          alu_op = 2'b01;
        end else begin
          alu_op  = 2'b00;
          alu_src = 1'b1;
        end
      end
      S_MEM: begin
        alu_src = 1'b1;
        dmem_rd = is_lw;
        dmem_wr = is_sw;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_r;
        mem_to_reg = is_lw;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  // Sequencer: state, PC and instruction register updates.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S_FETCH;
      pc_r    <= RESET_PC;
      ir_r    <= 32'h0000_0000;
      rst_q   <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      case (state_r)
        S_FETCH: begin
          if (imem_req && imem_ready) begin
            ir_r    <= imem_rdata;
            pc_r    <= pc_r + PC_STEP;
            state_r <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_j) begin
            pc_r    <= jump_tgt;
            state_r <= S_FETCH;
          end else if (is_ill) begin
            state_r <= S_FETCH;
          end else begin
            state_r <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_beq) begin
            if (alu_zero) begin
              pc_r <= pc_r + br_off;
            end
            state_r <= S_FETCH;
          end else if (is_lw || is_sw) begin
            state_r <= S_MEM;
          end else begin
            state_r <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            state_r <= is_lw ? S_WB : S_FETCH;
          end
        end
        S_WB: begin
          state_r <= S_FETCH;
        end
        default: begin
          state_r <= S_FETCH;
        end
      endcase
    end
  end

`ifdef MIPS_CTRL_PERF_EN
  logic retire_s;

  // An instruction retires when it leaves its final state; illegal ones never do.
  always_comb begin
    retire_s = ((state_r == S_DECODE) && is_j) ||
               ((state_r == S_EXEC) && is_beq) ||
               ((state_r == S_MEM) && is_sw && dmem_ready) ||
               (state_r == S_WB);
  end

  // Free-running cycle counter and retired-instruction counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_cnt <= 32'd0;
      ret_cnt <= 32'd0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (retire_s) begin
        ret_cnt <= ret_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl.
// Table of instructions with wait-state settings.
// The expected per-cycle control trace is queued, then popped and compared every cycle.
module tb_mips_multicycle_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        dmem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic        imem_req, dmem_rd, dmem_wr, reg_dst, alu_src, mem_to_reg, reg_write, illegal;
  logic [31:0] imem_addr, ir, pc;
  logic [1:0]  alu_op;
  logic [2:0]  state;
`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  mips_multicycle_ctrl #(.ADDR_W(32), .RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_ready(dmem_ready), .alu_zero(alu_zero),
    .ir(ir), .pc(pc), .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_op(alu_op), .state(state), .illegal(illegal)
`ifdef MIPS_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       illegal;
    logic       dmem_rd;
    logic       dmem_wr;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctl_t;

  typedef struct {
    logic [31:0] instr;
    int          iw;
    int          dw;
    logic        zero;
    logic [31:0] exp_pc;
  } vec_t;

  ctl_t sb_q[$];
  vec_t vecs[15];
  int   checks = 0;
  int   passes = 0;

  function automatic ctl_t dut_ctl();
    return {state, imem_req, illegal, dmem_rd, dmem_wr, alu_op, alu_src, reg_dst, mem_to_reg, reg_write};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected controls for a state, from the instruction's opcode.
  function automatic ctl_t exp_ctl(input logic [2:0] st, input logic [5:0] op);
    ctl_t c;
    c = '0;
    c.st = st;
    case (st)
      3'd0: c.imem_req = 1'b1;
      3'd1: c.illegal = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000});
      3'd2: begin
        c.alu_op  = (op == 6'b000000) ? 2'b10 : ((op == 6'b000100) ? 2'b01 : 2'b00);
        c.alu_src = (op inside {6'b100011, 6'b101011, 6'b001000});
      end
      3'd3: begin
        c.alu_src = 1'b1;
        c.dmem_rd = (op == 6'b100011);
        c.dmem_wr = (op == 6'b101011);
      end
      3'd4: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = (op == 6'b000000);
        c.mem_to_reg = (op == 6'b100011);
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Runs one instruction starting at a negedge in FETCH; ends at the next FETCH negedge.
  task automatic run_vec(input int idx, input vec_t v);
    logic [5:0] op;
    logic       legal;
    ctl_t       e;
    int         fc, mc, k;
    op    = v.instr[31:26];
    legal = (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000});
    for (int i = 0; i <= v.iw; i++) sb_q.push_back(exp_ctl(3'd0, op));
    sb_q.push_back(exp_ctl(3'd1, op));
    if (legal && op != 6'b000010) begin
      sb_q.push_back(exp_ctl(3'd2, op));
      if (op == 6'b100011 || op == 6'b101011) begin
        for (int i = 0; i <= v.dw; i++) sb_q.push_back(exp_ctl(3'd3, op));
      end
      if (op == 6'b000000 || op == 6'b001000 || op == 6'b100011) begin
        sb_q.push_back(exp_ctl(3'd4, op));
      end
    end
    fc = 0;
    mc = 0;
    k  = 0;
    while (sb_q.size() > 0) begin
      if (k > 0) @(negedge clock);
      e = sb_q.pop_front();
      check($sformatf("v%0d cyc%0d ctl", idx, k), 32'(dut_ctl()), 32'(e));
      if (e.st == 3'd1) check($sformatf("v%0d ir", idx), ir, v.instr);
      imem_rdata = v.instr;
      imem_ready = (e.st == 3'd0) && (fc == v.iw);
      dmem_ready = (e.st == 3'd3) && (mc == v.dw);
      alu_zero   = v.zero;
      if (e.st == 3'd0) fc++;
      if (e.st == 3'd3) mc++;
      k++;
    end
    @(negedge clock);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    check($sformatf("v%0d end state", idx), 32'(state), 32'd0);
    check($sformatf("v%0d pc", idx), pc, v.exp_pc);
  endtask

  initial begin
    vecs[0]  = '{32'h0022_1820, 0, 0, 1'b0, 32'h104};  // add $3,$1,$2
    vecs[1]  = '{32'h2001_0005, 1, 0, 1'b0, 32'h108};  // addi
    vecs[2]  = '{32'h8C22_0004, 3, 2, 1'b0, 32'h10C};  // lw, imem 3 waits, dmem 2 waits
    vecs[3]  = '{32'hAC22_0008, 0, 1, 1'b0, 32'h110};  // sw, dmem 1 wait
    vecs[4]  = '{32'h0800_0004, 0, 0, 1'b0, 32'h010};  // j 0x10
    vecs[5]  = '{32'h1000_FFFF, 0, 0, 1'b1, 32'h010};  // beq -1 taken
    vecs[6]  = '{32'h1000_FFFF, 0, 0, 1'b0, 32'h014};  // beq -1 not taken
    vecs[7]  = '{32'h0800_0008, 0, 0, 1'b0, 32'h020};  // j 0x20
    vecs[8]  = '{32'h0800_0040, 0, 0, 1'b0, 32'h100};  // j 0x40 -> 0x100
    vecs[9]  = '{32'hFC00_0000, 0, 0, 1'b0, 32'h104};  // opcode 0x3F illegal
    vecs[10] = '{32'h0400_0000, 1, 0, 1'b0, 32'h108};  // opcode 0x01 illegal
    vecs[11] = '{32'h1000_0003, 0, 0, 1'b1, 32'h118};  // beq +3 taken
    vecs[12] = '{32'h0000_0020, 2, 0, 1'b0, 32'h11C};  // R-type, imem 2 waits
    vecs[13] = '{32'hAC00_0000, 0, 0, 1'b0, 32'h120};  // sw no waits
    vecs[14] = '{32'h8C00_0000, 0, 0, 1'b0, 32'h124};  // lw no waits

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst state", 32'(state), 32'd0);
    check("rst pc", pc, RPC);
    check("rst ir", ir, 32'h0);
    check("rst controls", 32'(dut_ctl()), 32'h0);
    reset = 1'b0;
    @(negedge clock);
    check("post-rst imem_req", 32'(imem_req), 32'd1);
    check("post-rst imem_addr", imem_addr, RPC);

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

`ifdef MIPS_CTRL_PERF_EN
    check("ret_cnt", ret_cnt, 32'd13);
`endif

    // Reset while MEM waits on dmem_ready for a store
    imem_rdata = 32'hAC22_0008;
    imem_ready = 1'b1;
    @(negedge clock);
    imem_ready = 1'b0;
    check("t6 decode", 32'(state), 32'd1);
    @(negedge clock);
    @(negedge clock);
    check("t6 mem state", 32'(state), 32'd3);
    check("t6 dmem_wr", 32'(dmem_wr), 32'd1);
    @(negedge clock);
    check("t6 dmem_wr held", 32'(dmem_wr), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("t6 dmem_wr after rst", 32'(dmem_wr), 32'd0);
    check("t6 state after rst", 32'(state), 32'd0);
    check("t6 pc after rst", pc, RPC);
    check("t6 imem_req after rst", 32'(imem_req), 32'd0);
`ifdef MIPS_CTRL_PERF_EN
    check("ret_cnt cleared", ret_cnt, 32'd0);
    check("cyc_cnt cleared", cyc_cnt, 32'd0);
`endif
    reset = 1'b0;
    @(negedge clock);
    check("t6 imem_req resumes", 32'(imem_req), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
